// File: rtl/c3lib_rst_seq_pkg.sv
// c3lib_rst_seq_pkg: shared state encoding and width helpers for the reset sequencer
package c3lib_rst_seq_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_ACK, GAP, DONE, ERR} seq_state_e;
  function automatic int cnt_width(input int timeout, input int gap_cyc);
    return $clog2((timeout > gap_cyc ? timeout : gap_cyc) + 1);
  endfunction
  function automatic int idx_width(input int num_dom);
    return (num_dom > 1) ? $clog2(num_dom) : 1;
  endfunction
endpackage

// File: rtl/c3lib_rst_seq_sync.sv
// c3lib_rst_seq_sync: 2-stage synchronizer that clears to 0 on reset
module c3lib_rst_seq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] s0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0 <= '0;
      q  <= '0;
    end else begin
      s0 <= d;
      q  <= s0;
    end
  end
endmodule

// File: rtl/c3lib_rst_seq_ctrl.sv
// c3lib_rst_seq_ctrl: releases domain resets one at a time in index order, waiting on each ack with timeout
module c3lib_rst_seq_ctrl
  import c3lib_rst_seq_pkg::*;
#(
  parameter int NUM_DOM = 4,
  parameter int TIMEOUT = 1024,
  parameter int GAP_CYC = 4,
  localparam int IDX_W = idx_width(NUM_DOM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seq_req_async,
  input  logic [NUM_DOM-1:0] ack_async,
  output logic [NUM_DOM-1:0] rst_out,
  output logic               seq_done,
  output logic               seq_err,
  output logic [IDX_W-1:0]   err_idx
);
  localparam int CNT_W = cnt_width(TIMEOUT, GAP_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOM - 1);

  seq_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, eidx_q, eidx_d, idx_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [NUM_DOM-1:0] rst_q, rst_d, ack_s, nxt_mask;
  logic done_q, done_d, err_q, err_d, req_s;

  c3lib_rst_seq_sync #(.WIDTH(1)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (seq_req_async),
    .q   (req_s)
  );

  c3lib_rst_seq_sync #(.WIDTH(NUM_DOM)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack_async),
    .q   (ack_s)
  );

  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign idx_nxt  = idx_q + IDX_W'(1);
  assign nxt_mask = NUM_DOM'(1) << idx_nxt;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    done_d  = done_q;
    err_d   = err_q;
    eidx_d  = eidx_q;
    // a dropped request aborts from any active state
    if (state_q != IDLE && !req_s) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      rst_d   = '1;
      done_d  = 1'b0;
      err_d   = 1'b0;
      eidx_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          rst_d = '1;
          if (req_s) begin
            state_d = WAIT_ACK;
            idx_d   = '0;
            rst_d   = ~NUM_DOM'(1);
          end
        end
        WAIT_ACK: begin
          cnt_d = cnt_inc;
          if (ack_s[idx_q]) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
              done_d  = 1'b1;
              rst_d   = '0;
            end else if (GAP_CYC == 0) begin
              idx_d = idx_nxt;
              rst_d = rst_q & ~nxt_mask;
            end else begin
              state_d = GAP;
            end
          end else if (cnt_q == TO_LAST) begin
            state_d = ERR;
            rst_d   = '1;
            err_d   = 1'b1;
            eidx_d  = idx_q;
          end
        end
        GAP: begin
          cnt_d = cnt_inc;
          if (cnt_q == GAP_LAST) begin
            state_d = WAIT_ACK;
            idx_d   = idx_nxt;
            rst_d   = rst_q & ~nxt_mask;
            cnt_d   = '0;
          end
        end
        DONE: rst_d = '0;
        ERR:  rst_d = '1;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      eidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      err_q   <= err_d;
      eidx_q  <= eidx_d;
    end
  end

  assign rst_out  = rst_q;
  assign seq_done = done_q;
  assign seq_err  = err_q;
  assign err_idx  = eidx_q;
endmodule

// File: tb/tb_c3lib_rst_seq_ctrl.sv
// tb_c3lib_rst_seq_ctrl: randomized bench for the reset sequencer, one gapped and one gapless instance
module tb_c3lib_rst_seq_ctrl;
  import c3lib_rst_seq_pkg::*;
  localparam int N = 4;
  localparam int TO = 16;

  logic clk = 1'b0, rst = 1'b1, req_in = 1'b0;
  logic [N-1:0] ack_in = '0;
  logic [N-1:0] ro [2];
  logic done [2], err [2];
  logic [1:0] eidx [2];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  c3lib_rst_seq_ctrl #(.NUM_DOM(N), .TIMEOUT(TO), .GAP_CYC(4)) dut_a (
    .clk(clk), .rst(rst), .seq_req_async(req_in), .ack_async(ack_in),
    .rst_out(ro[0]), .seq_done(done[0]), .seq_err(err[0]), .err_idx(eidx[0])
  );

  c3lib_rst_seq_ctrl #(.NUM_DOM(N), .TIMEOUT(TO), .GAP_CYC(0)) dut_b (
    .clk(clk), .rst(rst), .seq_req_async(req_in), .ack_async(ack_in),
    .rst_out(ro[1]), .seq_done(done[1]), .seq_err(err[1]), .err_idx(eidx[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // reference: count of released domains plus wait/gap timers
  int m_rel [2], m_t [2], m_eidx [2];
  bit m_gap [2], m_done [2], m_err [2];
  bit r1, r2;
  logic [N-1:0] a1, a2;

  task automatic mclr(input int k);
    m_rel[k] = 0; m_t[k] = 0; m_gap[k] = 0; m_done[k] = 0; m_err[k] = 0; m_eidx[k] = 0;
  endtask

  task automatic mstep(input int k, input int g, input bit req, input logic [N-1:0] ack);
    if (!req) mclr(k);
    else if (m_err[k] || m_done[k]) begin
    end else if (m_rel[k] == 0) begin
      m_rel[k] = 1; m_t[k] = 0;
    end else if (m_gap[k]) begin
      m_t[k]++;
      if (m_t[k] == g) begin m_rel[k]++; m_gap[k] = 0; m_t[k] = 0; end
    end else if (ack[m_rel[k]-1]) begin
      m_t[k] = 0;
      if (m_rel[k] == N) m_done[k] = 1;
      else if (g == 0) m_rel[k]++;
      else m_gap[k] = 1;
    end else begin
      m_t[k]++;
      if (m_t[k] == TO) begin m_err[k] = 1; m_eidx[k] = m_rel[k] - 1; end
    end
  endtask

  function automatic logic [N-1:0] exp_rst(input int k);
    logic [31:0] m;
    m = (32'd1 << m_rel[k]) - 32'd1;
    return m_err[k] ? '1 : m_done[k] ? '0 : ~m[N-1:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      r1 = 0; r2 = 0; a1 = '0; a2 = '0;
      mclr(0); mclr(1);
    end else begin
      mstep(0, 4, r2, a2);
      mstep(1, 0, r2, a2);
      r2 = r1; a2 = a1; r1 = req_in; a1 = ack_in;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rst_out%0d", k), 32'(ro[k]), 32'(exp_rst(k)));
        chk($sformatf("done%0d", k), 32'(done[k]), 32'(m_done[k]));
        chk($sformatf("err%0d", k), 32'(err[k]), 32'(m_err[k]));
        chk($sformatf("eidx%0d", k), 32'(eidx[k]), m_err[k] ? 32'(m_eidx[k]) : 32'd0);
      end
    end
  end

  // ack driver: domain i acks dly[i] cycles after dut_a releases it (-1 = never)
  int dly [N];
  int ccnt [N];
  bit pre_ack = 0, drop_done = 0;
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      ccnt[i] = ro[0][i] ? 0 : ccnt[i] + 1;
      ack_in[i] = pre_ack || (!ro[0][i] && dly[i] >= 0 && ccnt[i] >= dly[i] && !(drop_done && done[0]));
    end
  end

  task automatic chk_rst_vals(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_ro"}, 32'(ro[k]), 32'hf);
      chk({tag, "_dn"}, 32'(done[k]), 0);
      chk({tag, "_er"}, 32'(err[k]), 0);
      chk({tag, "_ei"}, 32'(eidx[k]), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin dly[i] = 5; ccnt[i] = 0; end
    cyc(2);
    chk_rst_vals("reset");
    #2 rst = 1'b0;
    @(negedge clk); req_in = 1'b1;
    @(posedge clk); #1 chk("edge1", 32'(ro[0]), 32'hf);
    @(posedge clk); #1 chk("edge2", 32'(ro[0]), 32'hf);
    @(posedge clk); #1 chk("edge3", 32'(ro[0]), 32'he);
    for (int i = 0; i < 300 && !done[0]; i++) @(negedge clk);
    chk("nom_done", 32'(done[0]), 1);
    chk("nom_ro", 32'(ro[0]), 0);
    drop_done = 1; cyc(6);
    chk("done_hold", 32'(done[0]), 1);
    drop_done = 0; req_in = 1'b0; cyc(5);

    dly[2] = -1; req_in = 1'b1;
    for (int i = 0; i < 300 && !err[0]; i++) @(negedge clk);
    chk("to_err", 32'(err[0]), 1);
    chk("to_idx", 32'(eidx[0]), 2);
    chk("to_ro", 32'(ro[0]), 32'hf);
    cyc(10); chk("to_hold", 32'(err[0]), 1);
    req_in = 1'b0; cyc(2);
    chk("to_still", 32'(err[0]), 1);
    cyc(1); chk("to_clear", 32'(err[0]), 0);
    dly[2] = 5; cyc(3);

    req_in = 1'b1;
    for (int i = 0; i < 300 && ro[0] !== 4'b1100; i++) @(negedge clk);
    chk("ab_reach", 32'(ro[0]), 32'hc);
    cyc(1); req_in = 1'b0; cyc(3);
    chk("ab_ro", 32'(ro[0]), 32'hf);
    req_in = 1'b1;
    for (int i = 0; i < 20 && ro[0] !== 4'b1110; i++) @(negedge clk);
    chk("ab_restart", 32'(ro[0]), 32'he);
    req_in = 1'b0; cyc(5);

    dly[0] = 14; req_in = 1'b1;
    for (int i = 0; i < 400 && !done[0]; i++) @(negedge clk);
    chk("col_done", 32'(done[0]), 1);
    chk("col_err", 32'(err[0]), 0);
    dly[0] = 5; req_in = 1'b0; cyc(5);

    pre_ack = 1; cyc(3); req_in = 1'b1;
    for (int i = 0; i < 20 && ro[1] === 4'b1111; i++) @(negedge clk);
    chk("pre_first", 32'(ro[1]), 32'he);
    cyc(3); chk("pre_all", 32'(ro[1]), 0);
    chk("pre_nd", 32'(done[1]), 0);
    cyc(1); chk("pre_done", 32'(done[1]), 1);
    req_in = 1'b0; pre_ack = 0; cyc(5);

    req_in = 1'b1;
    for (int i = 0; i < 300 && dut_a.state_q != GAP; i++) @(negedge clk);
    chk("gap_reach", 32'(dut_a.state_q == GAP), 1);
    #2 rst = 1'b1;
    #1 chk_rst_vals("arst");
    cyc(2); #2 rst = 1'b0;
    @(posedge clk); #1 chk("rel1", 32'(ro[0]), 32'hf);
    @(posedge clk); #1 chk("rel2", 32'(ro[0]), 32'hf);
    @(posedge clk); #1 chk("rel3", 32'(ro[0]), 32'he);
    @(negedge clk); req_in = 1'b0; cyc(5);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) dly[i] = $urandom_range(0, 20);
      pre_ack = ($urandom_range(0, 5) == 0);
      drop_done = $urandom_range(0, 1) == 1;
      req_in = 1'b1;
      cyc($urandom_range(20, 160));
      req_in = 1'b0;
      cyc($urandom_range(3, 8));
      if (r % 10 == 9) begin
        #3 rst = 1'b1;
        #1 chk_rst_vals("rnd_arst");
        cyc(2); #2 rst = 1'b0;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
